// File: rtl/hebbian_trainer.sv
// Hebbian trainer: offers stimuli to a neuron, waits out its latency,
// turns the target/output difference into a saturated feedback error.
module hebbian_trainer #(
    parameter int NEURON_LATENCY = 1,
    parameter int ERR_SHIFT      = 8,
    parameter int CONV_THRESH    = 64,
    parameter int CONV_RUN       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] sample_input,
    input  logic [31:0] sample_target,
    input  logic        train_en,
    output logic [15:0] neuron_input,
    input  logic [31:0] neuron_output,
    output logic [15:0] feedback_error,
    output logic        enable_learning,
    output logic        err_valid,
    output logic [15:0] abs_err,
    output logic        converged,
    output logic [15:0] sample_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] UPDATE  = 2'd3;

    localparam logic [3:0]  LAT     = 4'(NEURON_LATENCY);
    localparam logic [15:0] THRESH  = 16'(CONV_THRESH);
    localparam logic [15:0] RUN_MAX = 16'(CONV_RUN);

    logic [1:0]         state;
    logic [3:0]         wait_cnt;
    logic [31:0]        target_q;
    logic               train_q;
    logic [15:0]        run_cnt;

    logic signed [32:0] diff;
    logic signed [32:0] shifted;
    logic [15:0]        fe_next;
    logic [15:0]        abs_next;
    logic [15:0]        run_next;

    assign sample_ready = (state == IDLE);

    // Error path: widen, floor-shift, clamp to 16 bits, then magnitude.
    always_comb begin
        diff     = $signed({target_q[31], target_q})
                 - $signed({neuron_output[31], neuron_output});
        shifted  = diff >>> ERR_SHIFT;
        fe_next  = shifted[15:0];
        abs_next = fe_next;
        run_next = 16'd0;
        if (shifted > 33'sd32767) begin
            fe_next = 16'h7FFF;
        end else if (shifted < -33'sd32768) begin
            fe_next = 16'h8000;
        end
        if (fe_next == 16'h8000) begin
            abs_next = 16'h7FFF;
        end else if (fe_next[15]) begin
            abs_next = ~fe_next + 16'd1;
        end else begin
            abs_next = fe_next;
        end
        if (abs_next <= THRESH) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 16'd1;
        end
    end

    // Sample sequencer: accept, wait for the neuron, capture, strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= 4'd0;
            target_q        <= 32'd0;
            train_q         <= 1'b0;
            run_cnt         <= 16'd0;
            neuron_input    <= 16'd0;
            feedback_error  <= 16'd0;
            abs_err         <= 16'd0;
            converged       <= 1'b0;
            sample_count    <= 16'd0;
            enable_learning <= 1'b0;
            err_valid       <= 1'b0;
        end else begin
            enable_learning <= 1'b0;
            err_valid       <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        neuron_input <= sample_input;
                        target_q     <= sample_target;
                        train_q      <= train_en;
                        wait_cnt     <= LAT;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    feedback_error  <= fe_next;
                    abs_err         <= abs_next;
                    run_cnt         <= run_next;
                    converged       <= (run_next == RUN_MAX);
                    err_valid       <= 1'b1;
                    enable_learning <= train_q;
                    state           <= UPDATE;
                end
                default: begin
                    sample_count <= sample_count + 16'd1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hebbian_trainer.sv
// Self-checking bench for hebbian_trainer with a behavioural neuron
// and an arithmetic reference model of the error/convergence rules.
module tb_hebbian_trainer;

    localparam int L     = 1;
    localparam int SHIFT = 8;
    localparam int THR   = 64;
    localparam int RUN   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_input;
    logic [31:0] sample_target;
    logic        train_en;
    logic [15:0] neuron_input;
    logic [31:0] neuron_output;
    logic [15:0] feedback_error;
    logic        enable_learning;
    logic        err_valid;
    logic [15:0] abs_err;
    logic        converged;
    logic [15:0] sample_count;

    int          checks = 0;
    int          errors = 0;

    // Neuron stand-in: product of input and weight, or a forced value.
    int          weight = 0;
    logic        ovr = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    // Reference state.
    int          m_run = 0;
    logic [15:0] m_count = 16'd0;

    hebbian_trainer #(
        .NEURON_LATENCY(L),
        .ERR_SHIFT(SHIFT),
        .CONV_THRESH(THR),
        .CONV_RUN(RUN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_input(sample_input),
        .sample_target(sample_target),
        .train_en(train_en),
        .neuron_input(neuron_input),
        .neuron_output(neuron_output),
        .feedback_error(feedback_error),
        .enable_learning(enable_learning),
        .err_valid(err_valid),
        .abs_err(abs_err),
        .converged(converged),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency neuron.
    always @(posedge clk) begin
        if (ovr) neuron_output <= ovr_val;
        else neuron_output <= 32'(int'($signed(neuron_input)) * weight);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_fe(input int tg, input int out);
        longint d, dv, q;
        d  = longint'(tg) - longint'(out);
        dv = longint'(1) << SHIFT;
        q  = d / dv;
        if (d < 0 && (d % dv) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [15:0] ref_abs(input logic [15:0] fe);
        int v;
        v = int'($signed(fe));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    task automatic do_sample(input logic [15:0] si, input logic [31:0] tg,
                             input logic te);
        int          out_v;
        logic [15:0] efe, eabs;
        @(negedge clk);
        sample_input  = si;
        sample_target = tg;
        train_en      = te;
        sample_valid  = 1'b1;
        chk("ready_before", 32'(sample_ready), 32'd1);
        @(posedge clk);
        #1;
        sample_valid  = 1'b0;
        sample_input  = 16'($urandom);
        sample_target = $urandom;
        train_en      = 1'($urandom);
        out_v = ovr ? int'(ovr_val) : int'($signed(si)) * weight;
        efe   = ref_fe(int'(tg), out_v);
        eabs  = ref_abs(efe);
        if (int'(eabs) <= THR) m_run = (m_run < RUN) ? m_run + 1 : m_run;
        else m_run = 0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            chk("wait_ready", 32'(sample_ready), 32'd0);
            chk("wait_ev", 32'(err_valid), 32'd0);
            chk("wait_el", 32'(enable_learning), 32'd0);
            chk("wait_nin", 32'(neuron_input), 32'(si));
        end
        @(negedge clk);
        chk("cap_ready", 32'(sample_ready), 32'd0);
        chk("cap_ev", 32'(err_valid), 32'd0);
        chk("cap_el", 32'(enable_learning), 32'd0);
        @(negedge clk);
        chk("upd_ev", 32'(err_valid), 32'd1);
        chk("upd_el", 32'(enable_learning), 32'(te));
        chk("upd_fe", 32'(feedback_error), 32'(efe));
        chk("upd_abs", 32'(abs_err), 32'(eabs));
        chk("upd_conv", 32'(converged), 32'(m_run == RUN));
        chk("upd_nin", 32'(neuron_input), 32'(si));
        chk("upd_ready", 32'(sample_ready), 32'd0);
        m_count = m_count + 16'd1;
        @(negedge clk);
        chk("post_ready", 32'(sample_ready), 32'd1);
        chk("post_count", 32'(sample_count), 32'(m_count));
        chk("post_ev", 32'(err_valid), 32'd0);
        chk("post_el", 32'(enable_learning), 32'd0);
        chk("post_fe_hold", 32'(feedback_error), 32'(efe));
    endtask

    initial begin
        int          o, d;
        logic [15:0] si;
        // Reset with a sample offered: it must not be taken.
        rst           = 1'b1;
        sample_valid  = 1'b1;
        sample_input  = 16'h1234;
        sample_target = 32'h5555;
        train_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_nin", 32'(neuron_input), 32'd0);
        chk("rst_fe", 32'(feedback_error), 32'd0);
        chk("rst_abs", 32'(abs_err), 32'd0);
        chk("rst_el", 32'(enable_learning), 32'd0);
        chk("rst_ev", 32'(err_valid), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_conv", 32'(converged), 32'd0);
        @(negedge clk);
        chk("idle_stays", 32'(sample_ready), 32'd1);

        // Reset while in WAIT drops the sample.
        weight        = 1058;
        sample_input  = 16'd77;
        sample_target = 32'd999;
        train_en      = 1'b1;
        sample_valid  = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("wr_ready", 32'(sample_ready), 32'd0);
        chk("wr_nin", 32'(neuron_input), 32'd77);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_ev", 32'(err_valid), 32'd0);
            chk("wr_el", 32'(enable_learning), 32'd0);
            chk("wr_count", 32'(sample_count), 32'd0);
            chk("wr_ready", 32'(sample_ready), 32'd1);
        end
        chk("wr_nin0", 32'(neuron_input), 32'd0);

        // Directed: positive, negative, saturation, evaluate-only.
        do_sample(16'd100, 32'd200000, 1'b1);
        chk("pos_fe", 32'(feedback_error), 32'd367);
        chk("pos_count", 32'(sample_count), 32'd1);
        do_sample(16'd100, 32'd0, 1'b1);
        chk("neg_fe", 32'(feedback_error), 32'(16'hFE62));
        chk("neg_abs", 32'(abs_err), 32'd414);
        ovr     = 1'b1;
        ovr_val = 32'h80000000;
        do_sample(16'd5, 32'h7FFFFFFF, 1'b1);
        chk("sat_hi", 32'(feedback_error), 32'h7FFF);
        ovr_val = 32'h7FFFFFFF;
        do_sample(16'd5, 32'h80000000, 1'b0);
        chk("sat_lo", 32'(feedback_error), 32'h8000);
        chk("sat_lo_abs", 32'(abs_err), 32'h7FFF);
        ovr = 1'b0;
        do_sample(16'd100, 32'd105800, 1'b0);

        // Break the run, then eight good samples, then one just over.
        ovr     = 1'b1;
        ovr_val = 32'd0;
        do_sample(16'd1, 32'd1000000, 1'b1);
        chk("run_broken", 32'(converged), 32'd0);
        ovr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            weight = int'($urandom_range(0, 2000)) - 1000;
            si     = 16'($urandom);
            o      = int'($signed(si)) * weight;
            d      = int'($urandom_range(0, 33023)) - 16384;
            do_sample(si, 32'(o + d), 1'($urandom));
        end
        chk("conv_set", 32'(converged), 32'd1);
        weight = 3;
        do_sample(16'd10, 32'(30 + 65 * 256), 1'b1);
        chk("conv_abs65", 32'(abs_err), 32'd65);
        chk("conv_clr", 32'(converged), 32'd0);

        // Unconstrained random samples.
        for (int k = 0; k < 20; k++) begin
            weight = int'($urandom);
            do_sample(16'($urandom), $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hebbian_trainer.md
HEBBIAN_TRAINER -- requirements
Module: hebbian_trainer

Interface
REQ-001 Parameter NEURON_LATENCY, default 1, SHALL set the cycles from neuron_input change to a valid neuron_output (legal range 1..15).
REQ-002 Parameter ERR_SHIFT, default 8, SHALL set the arithmetic right shift applied to the raw error before saturation.
REQ-003 Parameter CONV_THRESH, default 64, SHALL set the max abs_err (unsigned 16-bit) counted as a "good" sample.
REQ-004 Parameter CONV_RUN, default 8, SHALL set the consecutive good samples required to assert converged.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset: synchronous, active-high.
REQ-007 sample_valid  input  1  training sample offered.
REQ-008 sample_ready  output  1  trainer can accept a sample.
REQ-009 sample_input  input  16  signed stimulus for the neuron.
REQ-010 sample_target  input  32  signed desired neuron output.
REQ-011 train_en  input  1  sampled at acceptance; 0 = evaluate only, no learning pulse.
REQ-012 neuron_input  output  16  registered stimulus driven to the neuron's input_signal.
REQ-013 neuron_output  input  32  signed product returned by the neuron.
REQ-014 feedback_error  output  16  signed saturated error driven to the neuron.
REQ-015 enable_learning  output  1  one-cycle plasticity strobe to the neuron.
REQ-016 err_valid  output  1  one-cycle strobe; feedback_error/abs_err are fresh.
REQ-017 abs_err  output  16  unsigned magnitude of feedback_error.
REQ-018 converged  output  1  run of good samples has reached CONV_RUN.
REQ-019 sample_count  output  16  number of completed samples, wrapping.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, CAPTURE, UPDATE; sample_ready SHALL be 1 only in IDLE.
REQ-021 Handshake: a sample is accepted on a cycle with sample_valid & sample_ready; sample_valid without ready SHALL be ignored; inputs need only be stable on the accept cycle.
REQ-022 On accept: neuron_input <= sample_input, train_en and sample_target latched, wait counter <= NEURON_LATENCY, IDLE -> WAIT.
REQ-023 WAIT SHALL decrement the counter each cycle and move to CAPTURE when it reaches 0 (exactly NEURON_LATENCY WAIT cycles).
REQ-024 neuron_input SHALL hold its value from acceptance until the next acceptance, including through UPDATE.
REQ-025 CAPTURE (one cycle): diff = target - neuron_output in 33-bit signed; shifted = diff >>> ERR_SHIFT (floor toward -inf); result clamped to [-32768, 32767] and registered into feedback_error; CAPTURE -> UPDATE.
REQ-026 abs_err SHALL be registered with feedback_error as |feedback_error|, with -32768 mapped to 32767.
REQ-027 At the end of CAPTURE: if new abs_err <= CONV_THRESH the run counter SHALL increment (saturating at CONV_RUN), else clear to 0; converged = (run counter == CONV_RUN), updated on the same edge.
REQ-028 UPDATE (one cycle): err_valid = 1; enable_learning = latched train_en; sample_count increments at the end of UPDATE (0xFFFF -> 0x0000); UPDATE -> IDLE.
REQ-029 enable_learning and err_valid SHALL be 0 in all states other than UPDATE.
REQ-030 feedback_error and abs_err SHALL hold their last values outside CAPTURE updates.
REQ-031 Timing with acceptance at cycle 0: WAIT cycles 1..L, CAPTURE cycle L+1, UPDATE cycle L+2, sample_ready = 1 at cycle L+3; throughput one sample per L+3 cycles.

Reset
REQ-032 rst = 1 at a clock edge SHALL, from any state, force IDLE, discard any in-flight sample, and set neuron_input, feedback_error, abs_err, sample_count, the run counter, converged, enable_learning, err_valid to 0; sample_ready = 1 on the first cycle after rst deasserts.
REQ-033 A sample offered with rst = 1 SHALL NOT be accepted.

Verification
REQ-034 Reset: rst high for 2 cycles -> sample_ready=1, neuron_input=0, feedback_error=0, enable_learning=0, sample_count=0, converged=0.
REQ-035 L=1, SHIFT=8, neuron weight 1058: accept input=100, target=200000, train_en=1 -> neuron_output=105800, feedback_error=367, abs_err=367, enable_learning and err_valid high only in cycle 3, sample_ready=1 in cycle 4, sample_count=1.
REQ-036 Negative error: input=100, target=0, output 105800 -> feedback_error=-414, abs_err=414.
REQ-037 Saturation: target=0x7FFFFFFF, output=0x80000000 -> feedback_error=32767. Swapped values -> feedback_error=-32768, abs_err=32767.
REQ-038 train_en=0 sample -> err_valid pulses, enable_learning stays 0, sample_count increments. rst asserted during WAIT -> no strobes, sample_count unchanged.
REQ-039 Convergence: 8 samples with abs_err <= 64 -> converged=1 from the 8th UPDATE. A 9th sample with abs_err=65 -> converged=0 from its UPDATE.
